// File: rtl/spi_master_byte.sv
// spi_master_byte: single-word SPI mode-0 master (CPOL=0, CPHA=0).
//   Accepts a word on a valid/ready handshake. The word is shifted out
//   MSB-first on spi_mosi while spi_miso is sampled on every SCLK rise.
//   The received word is returned with a one-cycle rx_valid pulse.
//   Loss of pll_lock aborts any transfer in flight.
// Ports:
//   clk       system clock (100 MHz PLL output)
//   resetb    synchronous active-low reset
//   pll_lock  PLL lock flag; 0 blocks new transfers and aborts an active one
//   tx_valid / tx_ready / tx_data   transmit handshake and word
//   rx_valid / rx_data              receive pulse and held word
//   spi_sclk / spi_mosi / spi_miso / spi_cs_n   SPI bus
module spi_master_byte #(
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned HALF_DIV = 4,
  parameter int unsigned CS_GUARD = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              pll_lock,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int unsigned DIV_W = $clog2(HALF_DIV + 1);
  localparam int unsigned GRD_W = $clog2(CS_GUARD + 1);
  localparam int unsigned BIT_W = $clog2(BYTE_W + 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, XFER, CS_HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [GRD_W-1:0]    grd_q, grd_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   tx_sr_q, tx_sr_d;
  logic [BYTE_W-1:0]   rx_sr_q, rx_sr_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_ready_q, tx_ready_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    grd_d      = grd_q;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[BYTE_W-1];
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          grd_d   = '0;
          bit_d   = '0;
        end
      end
      CS_SETUP: begin
        if (grd_q == GRD_W'(CS_GUARD - 1)) begin
          state_d = XFER;
          div_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          grd_d = grd_q + 1'b1;
        end
      end
      XFER: begin
        if (div_q == DIV_W'(HALF_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // rising edge: capture MISO into the LSB
            rx_sr_d = {rx_sr_q[BYTE_W-2:0], spi_miso};
          end else if (bit_q == BIT_W'(BYTE_W - 1)) begin
            // falling edge after the final bit
            state_d = CS_HOLD;
            mosi_d  = 1'b0;
            grd_d   = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_q[BYTE_W-2];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      CS_HOLD: begin
        if (grd_q == GRD_W'(CS_GUARD - 1)) begin
          state_d    = IDLE;
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end else begin
          grd_d = grd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lock loss overrides whatever the active state decided, including a
    // CS_HOLD exit, so an aborted frame never reports data.
    if (state_q != IDLE && !pll_lock) begin
      state_d    = IDLE;
      cs_n_d     = 1'b1;
      sclk_d     = 1'b0;
      mosi_d     = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
    end

    // Looking at the next state lets ready rise alongside rx_valid, so the
    // next handshake can land one cycle after the frame ends.
    tx_ready_d = pll_lock && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q    <= IDLE;
      div_q      <= '0;
      grd_q      <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      grd_q      <= grd_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Testbench for spi_master_byte: default-parameter instance (a) with a
// loopback/slave MISO source, plus a 16-bit fast instance (b) in loopback.
module tb_spi_master_byte;

  localparam int W = 8, H = 4, G = 2;
  localparam int WB = 16, HB = 1, GB = 1;

  logic clk = 1'b0;
  logic resetb, pll_lock;

  logic         tx_valid_a, tx_ready_a, rx_valid_a, sclk_a, mosi_a, miso_a, cs_n_a;
  logic [W-1:0] tx_data_a, rx_data_a;

  logic          tx_valid_b, tx_ready_b, rx_valid_b, sclk_b, mosi_b, cs_n_b;
  logic [WB-1:0] tx_data_b, rx_data_b;

  bit           lb;
  logic [W-1:0] slave_word;
  int           sidx;
  logic [W-1:0] last_rx;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  // Slave model: presents MSB first on CS fall, advances on each SCLK fall.
  always @(negedge sclk_a or posedge cs_n_a)
    if (cs_n_a) sidx <= 0;
    else        sidx <= sidx + 1;
  assign miso_a = lb ? mosi_a : ((sidx < W) ? slave_word[3'(W - 1 - sidx)] : 1'b0);

  spi_master_byte dut_a (
    .clk(clk), .resetb(resetb), .pll_lock(pll_lock),
    .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .rx_valid(rx_valid_a), .rx_data(rx_data_a),
    .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .spi_cs_n(cs_n_a)
  );

  spi_master_byte #(.BYTE_W(WB), .HALF_DIV(HB), .CS_GUARD(GB)) dut_b (
    .clk(clk), .resetb(resetb), .pll_lock(pll_lock),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(mosi_b), .spi_cs_n(cs_n_b)
  );

  task automatic test_reset();
    resetb = 1'b0; pll_lock = 1'b0; lb = 1'b1; slave_word = '0;
    tx_valid_a = 1'b0; tx_data_a = '0; tx_valid_b = 1'b0; tx_data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({tx_ready_a, rx_valid_a, rx_data_a, sclk_a, mosi_a, cs_n_a} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_a: got rdy=%b rxv=%b rxd=%h sclk=%b mosi=%b csn=%b expected 0 0 00 0 0 1",
               tx_ready_a, rx_valid_a, rx_data_a, sclk_a, mosi_a, cs_n_a);
    else pass_cnt++;
    chk_cnt++;
    if ({tx_ready_b, rx_valid_b, rx_data_b, sclk_b, mosi_b, cs_n_b} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_b: got rdy=%b rxv=%b rxd=%h sclk=%b mosi=%b csn=%b expected 0 0 0000 0 0 1",
               tx_ready_b, rx_valid_b, rx_data_b, sclk_b, mosi_b, cs_n_b);
    else pass_cnt++;
    last_rx = '0;
  endtask

  // Full frame on instance a, every timing derived from the protocol rules.
  task automatic do_xfer_a(input logic [W-1:0] txw, input bit loop, input logic [W-1:0] slv);
    int rise_t[$]; logic mosi_r[$]; int stab[$];
    int rv_t, rv_n, cs_t, last_chg, n, bad_t, bad_m, bad_s;
    logic [W-1:0] rv_d, exp_rx;
    logic psclk, pmosi;
    lb = loop; slave_word = slv;
    exp_rx = loop ? txw : slv;
    @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = txw; n = 0;
    while (!tx_ready_a && n < 200) begin @(negedge clk); n++; end
    chk_cnt++;
    if (!tx_ready_a) begin
      $display("FAIL handshake_a: tx_ready=%b after %0d cycles, expected 1", tx_ready_a, n);
      tx_valid_a = 1'b0;
      return;
    end else pass_cnt++;
    @(posedge clk); #1;
    tx_valid_a = 1'b0; tx_data_a = W'($urandom);
    chk_cnt++;
    if (cs_n_a !== 1'b0 || mosi_a !== txw[W-1])
      $display("FAIL start_a: csn=%b mosi=%b expected 0 %b", cs_n_a, mosi_a, txw[W-1]);
    else pass_cnt++;
    psclk = sclk_a; pmosi = mosi_a; last_chg = 0; rv_n = 0; rv_t = -1; cs_t = -1; rv_d = '0;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk); #1;
      if (sclk_a && !psclk) begin
        rise_t.push_back(t); mosi_r.push_back(mosi_a); stab.push_back(t - last_chg);
      end
      if (mosi_a !== pmosi) last_chg = t;
      if (rx_valid_a) begin rv_n++; if (rv_t < 0) begin rv_t = t; rv_d = rx_data_a; end end
      if (cs_n_a && cs_t < 0) cs_t = t;
      psclk = sclk_a; pmosi = mosi_a;
    end
    chk_cnt++;
    if (rise_t.size() != W) $display("FAIL rise_count: got %0d expected %0d", rise_t.size(), W);
    else pass_cnt++;
    bad_t = 0; bad_m = 0; bad_s = 0;
    for (int k = 0; k < rise_t.size() && k < W; k++) begin
      if (rise_t[k] != G + H * (2 * k + 1)) bad_t++;
      if (mosi_r[k] !== txw[W-1-k]) bad_m++;
      if (stab[k] < H) bad_s++;
    end
    chk_cnt++;
    if (bad_t != 0) $display("FAIL rise_times: %0d wrong, first rise at %0d expected %0d", bad_t,
                             (rise_t.size() > 0) ? rise_t[0] : -1, G + H);
    else pass_cnt++;
    chk_cnt++;
    if (bad_m != 0 || bad_s != 0)
      $display("FAIL mosi_at_rise: %0d wrong bits, %0d unstable, tx=%h expected 0 0", bad_m, bad_s, txw);
    else pass_cnt++;
    chk_cnt++;
    if (rv_n != 1 || rv_t != 2 * G + 2 * H * W)
      $display("FAIL rx_valid_timing: got %0d pulses first at %0d expected 1 at %0d", rv_n, rv_t, 2 * G + 2 * H * W);
    else pass_cnt++;
    chk_cnt++;
    if (rv_d !== exp_rx || rx_data_a !== exp_rx)
      $display("FAIL rx_data: got %h (held %h) expected %h", rv_d, rx_data_a, exp_rx);
    else pass_cnt++;
    chk_cnt++;
    if (cs_t != 2 * G + 2 * H * W) $display("FAIL cs_rise: got %0d expected %0d", cs_t, 2 * G + 2 * H * W);
    else pass_cnt++;
    last_rx = exp_rx;
  endtask

  task automatic test_loopback();
    do_xfer_a(8'hA5, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) do_xfer_a(W'($urandom), 1'b1, 8'h00);
  endtask

  task automatic test_slave();
    do_xfer_a(8'hFF, 1'b0, 8'h3C);
    for (int i = 0; i < 2; i++) do_xfer_a(W'($urandom), 1'b0, W'($urandom));
  endtask

  task automatic test_lock_gate();
    int bad, n;
    lb = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = 8'h6B; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx_ready_a !== 1'b0 || cs_n_a !== 1'b1 || sclk_a !== 1'b0) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL lock_low_idle: %0d bad cycles expected 0", bad);
    else pass_cnt++;
    pll_lock = 1'b1; n = 0;
    while (cs_n_a !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
    tx_valid_a = 1'b0;
    chk_cnt++;
    if (n > 2) $display("FAIL lock_start: cs low after %0d cycles expected <=2", n);
    else pass_cnt++;
    repeat (80) @(posedge clk);
    #1;
    chk_cnt++;
    if (rx_data_a !== 8'h6B) $display("FAIL lock_frame_rx: got %h expected 6b", rx_data_a);
    else pass_cnt++;
    last_rx = 8'h6B;
  endtask

  task automatic test_abort();
    int rises, n, rv_n;
    logic psclk;
    lb = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = 8'h81; n = 0;
    while (!tx_ready_a && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    rises = 0; psclk = sclk_a; n = 0;
    while (rises < 3 && n < 100) begin
      @(posedge clk); #1; n++;
      if (sclk_a && !psclk) rises++;
      psclk = sclk_a;
    end
    pll_lock = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (rises != 3 || cs_n_a !== 1'b1 || sclk_a !== 1'b0 || mosi_a !== 1'b0)
      $display("FAIL abort_lines: rises=%0d csn=%b sclk=%b mosi=%b expected 3 1 0 0", rises, cs_n_a, sclk_a, mosi_a);
    else pass_cnt++;
    rv_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_valid_a) rv_n++;
    end
    pll_lock = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_valid_a || cs_n_a !== 1'b1) rv_n++;
    end
    chk_cnt++;
    if (rv_n != 0 || rx_data_a !== last_rx)
      $display("FAIL abort_rx: %0d bad cycles rx_data=%h expected 0 %h", rv_n, rx_data_a, last_rx);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int rv_t[$]; logic [W-1:0] rv_d[$];
    int n, gap;
    bit counting;
    lb = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = 8'h01; n = 0;
    while (!tx_ready_a && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    tx_data_a = 8'h80;
    gap = 0; counting = 1'b0;
    for (int t = 1; t <= 180; t++) begin
      @(posedge clk); #1;
      if (rx_valid_a) begin
        rv_t.push_back(t); rv_d.push_back(rx_data_a);
        if (rv_t.size() == 1) counting = 1'b1;
        if (rv_t.size() == 2) tx_valid_a = 1'b0;
      end
      if (counting) begin
        if (cs_n_a) gap++;
        else counting = 1'b0;
      end
    end
    tx_valid_a = 1'b0;
    chk_cnt++;
    if (rv_t.size() != 2 || rv_t[1] - rv_t[0] != 2 * G + 2 * H * W + 1)
      $display("FAIL b2b_spacing: got %0d pulses spacing %0d expected 2 %0d", rv_t.size(),
               (rv_t.size() >= 2) ? rv_t[1] - rv_t[0] : -1, 2 * G + 2 * H * W + 1);
    else pass_cnt++;
    chk_cnt++;
    if (rv_d.size() != 2 || rv_d[0] !== 8'h01 || rv_d[1] !== 8'h80 || gap < 1)
      $display("FAIL b2b_data: got %0d words first %h gap %0d expected 01,80 gap>=1",
               rv_d.size(), (rv_d.size() > 0) ? rv_d[0] : 8'hxx, gap);
    else pass_cnt++;
    last_rx = 8'h80;
  endtask

  task automatic test_wide_fast();
    logic [WB-1:0] txw;
    int rise_t[$]; int rv_t, n, bad;
    logic psclk;
    logic [WB-1:0] rv_d;
    for (int r = 0; r < 2; r++) begin
      txw = (r == 0) ? 16'hBEEF : WB'($urandom);
      @(negedge clk);
      tx_valid_b = 1'b1; tx_data_b = txw; n = 0;
      while (!tx_ready_b && n < 200) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      tx_valid_b = 1'b0; tx_data_b = WB'($urandom);
      rise_t.delete(); rv_t = -1; rv_d = '0; psclk = sclk_b;
      for (int t = 1; t <= 50; t++) begin
        @(posedge clk); #1;
        if (sclk_b && !psclk) rise_t.push_back(t);
        if (rx_valid_b && rv_t < 0) begin rv_t = t; rv_d = rx_data_b; end
        psclk = sclk_b;
      end
      bad = (rise_t.size() == WB) ? 0 : 1;
      for (int k = 0; k < rise_t.size(); k++)
        if (rise_t[k] != GB + HB * (2 * k + 1)) bad++;
      chk_cnt++;
      if (bad != 0) $display("FAIL wide_rises: %0d errors, %0d rises expected %0d period %0d", bad, rise_t.size(), WB, 2 * HB);
      else pass_cnt++;
      chk_cnt++;
      if (rv_t != 2 * GB + 2 * HB * WB || rv_d !== txw)
        $display("FAIL wide_rx: got %h at %0d expected %h at %0d", rv_d, rv_t, txw, 2 * GB + 2 * HB * WB);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    lb = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = W'($urandom); n = 0;
    while (!tx_ready_a && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    resetb = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if ({tx_ready_a, rx_valid_a, rx_data_a, sclk_a, mosi_a, cs_n_a} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_mid: got rdy=%b rxv=%b rxd=%h sclk=%b mosi=%b csn=%b expected 0 0 00 0 0 1",
               tx_ready_a, rx_valid_a, rx_data_a, sclk_a, mosi_a, cs_n_a);
    else pass_cnt++;
    @(negedge clk);
    resetb = 1'b1;
    last_rx = '0;
    do_xfer_a(8'h55, 1'b1, 8'h00);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    resetb = 1'b1;
    test_lock_gate();
    test_loopback();
    test_slave();
    test_abort();
    test_back_to_back();
    test_wide_fast();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
